// File: rtl/tlb_miss_fifo.sv
// TLB miss queue: a DEPTH-entry circular FIFO of pending TLB misses that sits
// between the TLB and the page-table walker. A new miss is dropped if a valid
// entry already holds the same page and ASID, so the walker never sees repeats.
// The oldest miss is offered to the walker through a miss_o / missack handshake.
module tlb_miss_fifo #(
    parameter int DEPTH        = 8,
    parameter int LOG_PAGESIZE = 13,
    parameter int VA_W         = 32,
    parameter int ASID_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rst_busy,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [VA_W-1:0]          miss_adr,
    input  logic [ASID_W-1:0]        miss_asid,
    input  logic [7:0]               miss_id,
    input  logic                     miss_v,
    input  logic                     missack,
    output logic [VA_W-1:0]          miss_adr_o,
    output logic [ASID_W-1:0]        miss_asid_o,
    output logic [7:0]               miss_id_o,
    output logic                     miss_o,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [VA_W-1:0]   adr_r  [DEPTH];
    logic [ASID_W-1:0] asid_r [DEPTH];
    logic [7:0]        id_r   [DEPTH];
    logic [DEPTH-1:0]  v_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              overflow_r;

    logic              cand_s;
    logic              dup_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              ovf_s;

    assign full_s = (count_r == DEPTH_C);

    // Duplicate detection against every valid entry (head included) and push/pop decisions.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (v_r[i] &&
                (adr_r[i][VA_W-1:LOG_PAGESIZE] == miss_adr[VA_W-1:LOG_PAGESIZE]) &&
                (asid_r[i] == miss_asid)) begin
                dup_s = 1'b1;
            end else begin
                dup_s = dup_s;
            end
        end
        cand_s = miss_v & ~stall & ~rst_busy & ~flush;
        pop_s  = missack & (count_r != {CW{1'b0}}) & ~flush;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push_s = cand_s & ~dup_s & (~full_s | pop_s);
        ovf_s  = cand_s & ~dup_s & full_s & ~pop_s;
    end

    // Queue state: entries, pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr_r[i]  <= {VA_W{1'b0}};
                asid_r[i] <= {ASID_W{1'b0}};
                id_r[i]   <= 8'd0;
            end
            v_r        <= {DEPTH{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            v_r        <= {DEPTH{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= ovf_s;
            if (pop_s) begin
                v_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r      <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            // Written after the pop so a full-queue push into the freed slot wins the valid bit.
            if (push_s) begin
                adr_r[wr_ptr_r]  <= miss_adr;
                asid_r[wr_ptr_r] <= miss_asid;
                id_r[wr_ptr_r]   <= miss_id;
                v_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r         <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry fields are forced to zero whenever the head slot is empty.
    always_comb begin
        if (v_r[rd_ptr_r]) begin
            miss_adr_o  = adr_r[rd_ptr_r];
            miss_asid_o = asid_r[rd_ptr_r];
            miss_id_o   = id_r[rd_ptr_r];
        end else begin
            miss_adr_o  = {VA_W{1'b0}};
            miss_asid_o = {ASID_W{1'b0}};
            miss_id_o   = 8'd0;
        end
    end

    assign miss_o   = (count_r != {CW{1'b0}});
    assign full     = full_s;
    assign overflow = overflow_r;
    assign count    = count_r;

endmodule

// File: tb/tb_tlb_miss_fifo.sv
// Directed bench for tlb_miss_fifo. A reference queue holds the entries the
// walker should see, in order; each step updates it and compares the DUT.
module tb_tlb_miss_fifo;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] adr;
        logic [15:0] asid;
        logic [7:0]  id;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_busy = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] miss_adr = 32'd0;
    logic [15:0] miss_asid = 16'd0;
    logic [7:0]  miss_id = 8'd0;
    logic        miss_v = 1'b0;
    logic        missack = 1'b0;
    logic [31:0] miss_adr_o;
    logic [15:0] miss_asid_o;
    logic [7:0]  miss_id_o;
    logic        miss_o;
    logic        full;
    logic        overflow;
    logic [3:0]  count;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    logic exp_ovf;

    tlb_miss_fifo #(.DEPTH(DEPTH), .LOG_PAGESIZE(13), .VA_W(32), .ASID_W(16)) dut (
        .clk(clk), .rst(rst), .rst_busy(rst_busy), .stall(stall), .flush(flush),
        .miss_adr(miss_adr), .miss_asid(miss_asid), .miss_id(miss_id),
        .miss_v(miss_v), .missack(missack),
        .miss_adr_o(miss_adr_o), .miss_asid_o(miss_asid_o), .miss_id_o(miss_id_o),
        .miss_o(miss_o), .full(full), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue.
    task automatic check_all(input string tag);
        chk({tag, ".count"}, {28'd0, count}, q.size());
        chk({tag, ".miss_o"}, {31'd0, miss_o}, {31'd0, q.size() != 0});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, q.size() == DEPTH});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        if (q.size() != 0) begin
            chk({tag, ".adr"}, miss_adr_o, q[0].adr);
            chk({tag, ".asid"}, {16'd0, miss_asid_o}, {16'd0, q[0].asid});
            chk({tag, ".id"}, {24'd0, miss_id_o}, {24'd0, q[0].id});
        end else begin
            chk({tag, ".adr0"}, miss_adr_o, 32'd0);
        end
    endtask

    // One clock: drive at negedge, update the reference, check 1 time unit after posedge.
    task automatic step(input string tag, input logic mv, input logic [31:0] adr,
                        input logic [15:0] asid, input logic [7:0] id,
                        input logic ack, input logic fl);
        logic dup;
        logic pop;
        @(negedge clk);
        miss_v = mv; miss_adr = adr; miss_asid = asid; miss_id = id;
        missack = ack; flush = fl;
        exp_ovf = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            dup = 1'b0;
            foreach (q[i]) if (q[i].adr[31:13] == adr[31:13] && q[i].asid == asid) dup = 1'b1;
            pop = ack && (q.size() != 0);
            if (pop) void'(q.pop_front());
            if (mv && !stall && !rst_busy && !dup) begin
                if (q.size() < DEPTH) q.push_back('{adr, asid, id});
                else exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        miss_v = 1'b0; missack = 1'b0; flush = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_ovf = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: first miss visible the next cycle
        step("push1", 1'b1, 32'h0001_2000, 16'd5, 8'd3, 1'b0, 1'b0);
        // 2: same page/asid dropped (id 9 not kept); new asid queued
        step("dup_page", 1'b1, 32'h0001_2FF8, 16'd5, 8'd9, 1'b0, 1'b0);
        step("new_asid", 1'b1, 32'h0001_2000, 16'd6, 8'd4, 1'b0, 1'b0);
        chk("t2.count", {28'd0, count}, 32'd2);
        chk("t2.head_id", {24'd0, miss_id_o}, 32'd3);
        step("flush_a", 1'b0, 32'd0, 16'd0, 8'd0, 1'b0, 1'b1);

        // 3: fill, then overflow on a 9th distinct page
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1'b1, 32'h0010_0000 + (i << 13), 16'd1, 8'(i + 16), 1'b0, 1'b0);
        step("ovf", 1'b1, 32'h0020_0000, 16'd1, 8'd99, 1'b0, 1'b0);
        chk("t3.ovf", {31'd0, overflow}, 32'd1);
        idle("ovf_gone");
        step("dup_full", 1'b1, 32'h0010_2010, 16'd1, 8'd77, 1'b0, 1'b0);
        // 4: full with pop and new push in the same cycle
        step("full_pushpop", 1'b1, 32'h0030_0000, 16'd2, 8'd55, 1'b1, 1'b0);
        chk("t4.count", {28'd0, count}, 32'd8);
        // pushing the popped head's page again right as it pops is still a duplicate
        step("dup_head_pop", 1'b1, 32'h0010_2000, 16'd1, 8'd66, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("drain", 1'b0, 32'd0, 16'd0, 8'd0, 1'b1, 1'b0);
        chk("t4.empty", {28'd0, count}, 32'd0);
        step("ack_empty", 1'b0, 32'd0, 16'd0, 8'd0, 1'b1, 1'b0);

        // 5: flush wins over a simultaneous push
        for (int i = 0; i < 3; i++)
            step("push3", 1'b1, 32'h0040_0000 + (i << 13), 16'd3, 8'(i), 1'b0, 1'b0);
        step("flush_push", 1'b1, 32'h0050_0000, 16'd3, 8'd7, 1'b1, 1'b1);
        chk("t5.miss_o", {31'd0, miss_o}, 32'd0);
        idle("post_flush");

        // 6: stall and rst_busy block pushes
        stall = 1'b1;
        step("stall", 1'b1, 32'h0060_0000, 16'd4, 8'd1, 1'b0, 1'b0);
        stall = 1'b0; rst_busy = 1'b1;
        step("busy", 1'b1, 32'h0060_0000, 16'd4, 8'd1, 1'b0, 1'b0);
        rst_busy = 1'b0;
        step("wrap_a", 1'b1, 32'h0070_0000, 16'd4, 8'd2, 1'b0, 1'b0);
        step("wrap_b", 1'b1, 32'h0070_2000, 16'd4, 8'd3, 1'b0, 1'b0);
        chk("t6.count", {28'd0, count}, 32'd2);

        // async reset mid-queue, checked with no clock edge in between
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        exp_ovf = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
